// File: rtl/systolic_sequencer.sv
// Job sequencer for a ROWS x COLS weight-stationary array: buffers one weight tile,
// shifts it in bottom row first, streams skewed input vectors, then drains.
module systolic_sequencer #(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CNT_W-1:0]           num_vecs,
    output logic                       busy,
    output logic                       done,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [COLS*DATA_WIDTH-1:0] w_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    output logic [COLS*DATA_WIDTH-1:0] arr_weight,
    output logic [COLS-1:0]            arr_accept_w,
    output logic [ROWS*DATA_WIDTH-1:0] arr_input,
    output logic [ROWS-1:0]            arr_valid,
    output logic [ROWS-1:0]            arr_switch,
    output logic                       arr_enabled
);

    localparam int              PW         = $clog2(ROWS + COLS + 1);
    localparam int              WW         = COLS * DATA_WIDTH;
    localparam logic [PW-1:0]   ROW_LAST   = PW'(ROWS - 1);
    localparam logic [PW-1:0]   DRAIN_LAST = PW'(ROWS + COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_W, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     phase_cnt_reg, phase_cnt_next;
    logic [CNT_W-1:0]  vec_cnt_reg, num_vecs_reg;
    logic              first_reg;
    logic [WW-1:0]     wbuf_reg [ROWS];
    logic [WW-1:0]     weight_next;
    logic              accept_next;
    logic              w_fire, in_fire, last_vec;

    assign w_fire   = w_valid && w_ready;
    assign in_fire  = in_valid && in_ready;
    assign last_vec = (vec_cnt_reg + CNT_W'(1)) == num_vecs_reg;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            phase_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
        end
    end

    // Next-state logic; phase_cnt counts beats in FETCH_W and cycles in LOAD_W/DRAIN
    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next     = S_FETCH_W;
                    phase_cnt_next = '0;
                end
            end
            S_FETCH_W: begin
                if (w_fire) begin
                    if (phase_cnt_reg == ROW_LAST) begin
                        state_next     = S_LOAD_W;
                        phase_cnt_next = '0;
                    end else begin
                        phase_cnt_next = phase_cnt_reg + PW'(1);
                    end
                end
            end
            S_LOAD_W: begin
                if (phase_cnt_reg == ROW_LAST) begin
                    state_next     = (num_vecs_reg != '0) ? S_STREAM : S_DRAIN;
                    phase_cnt_next = '0;
                end else begin
                    phase_cnt_next = phase_cnt_reg + PW'(1);
                end
            end
            S_STREAM: begin
                if (in_fire && last_vec) begin
                    state_next     = S_DRAIN;
                    phase_cnt_next = '0;
                end
            end
            S_DRAIN: begin
                if (phase_cnt_reg == DRAIN_LAST) begin
                    state_next     = S_DONE;
                    phase_cnt_next = '0;
                end else begin
                    phase_cnt_next = phase_cnt_reg + PW'(1);
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode; weight_next is what the top edge shows in the following cycle
    always_comb begin
        busy        = (state_reg != S_IDLE);
        done        = (state_reg == S_DONE);
        w_ready     = (state_reg == S_FETCH_W);
        in_ready    = (state_reg == S_STREAM);
        arr_enabled = busy;
        weight_next = '0;
        accept_next = 1'b0;
        if (state_reg == S_FETCH_W && w_fire && phase_cnt_reg == ROW_LAST) begin
            // Bottom row is the beat arriving now: bypass it straight out
            weight_next = w_data;
            accept_next = 1'b1;
        end else if (state_reg == S_LOAD_W && phase_cnt_reg != ROW_LAST) begin
            accept_next = 1'b1;
            for (int k = 0; k < ROWS; k++) begin
                if (phase_cnt_reg == PW'(ROWS - 2 - k))
                    weight_next = wbuf_reg[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_vecs_reg <= '0;
            vec_cnt_reg  <= '0;
            first_reg    <= 1'b0;
            arr_weight   <= '0;
            arr_accept_w <= '0;
        end else begin
            if (state_reg == S_IDLE && start) begin
                num_vecs_reg <= num_vecs;
                vec_cnt_reg  <= '0;
                first_reg    <= 1'b1;
            end else if (in_fire) begin
                vec_cnt_reg  <= vec_cnt_reg + CNT_W'(1);
                first_reg    <= 1'b0;
            end
            arr_weight   <= weight_next;
            arr_accept_w <= {COLS{accept_next}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < ROWS; k++)
                wbuf_reg[k] <= '0;
        end else if (w_fire) begin
            for (int k = 0; k < ROWS; k++) begin
                if (phase_cnt_reg == PW'(k))
                    wbuf_reg[k] <= w_data;
            end
        end
    end

    // Row gi sees a vector accepted at cycle t at cycle t+1+gi
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_skew
            logic [DATA_WIDTH-1:0] data_reg   [gi+1];
            logic                  valid_reg  [gi+1];
            logic                  switch_reg [gi+1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s <= gi; s++) begin
                        data_reg[s]   <= '0;
                        valid_reg[s]  <= 1'b0;
                        switch_reg[s] <= 1'b0;
                    end
                end else begin
                    data_reg[0]   <= in_fire ? in_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                    valid_reg[0]  <= in_fire;
                    switch_reg[0] <= in_fire && first_reg;
                    for (int s = 1; s <= gi; s++) begin
                        data_reg[s]   <= data_reg[s-1];
                        valid_reg[s]  <= valid_reg[s-1];
                        switch_reg[s] <= switch_reg[s-1];
                    end
                end
            end

            assign arr_input[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg[gi];
            assign arr_valid[gi]  = valid_reg[gi];
            assign arr_switch[gi] = switch_reg[gi];
        end
    endgenerate

endmodule
